// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared RV32M encodings, sequencer states and signedness helpers.
package muldiv_seq_pkg;
  localparam int MULDIV_ITER = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;
  function automatic logic rs1_signed(logic [2:0] f);
    return f == F3_MULH || f == F3_MULHSU || f == F3_DIV || f == F3_REM;
  endfunction
  function automatic logic rs2_signed(logic [2:0] f);
    return f == F3_MULH || f == F3_DIV || f == F3_REM;
  endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: execute-stage request/result bundle for the multiply/divide sequencer.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            stall;
  logic            valid_out;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, rs1, rs2, flush, input stall, valid_out, result);
  modport slave (input start, funct3, rs1, rs2, flush, output stall, valid_out, result);
endinterface

// File: rtl/muldiv_seq_cneg.sv
// muldiv_cneg: conditional two's-complement negate.
module muldiv_cneg #(parameter int W = 32) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);
  assign y_o = neg_i ? -a_i : a_i;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer, shift-add multiply and restoring divide on magnitudes.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = MULDIV_ITER
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  md_state_e         state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              is_div_i, is_div_q, sa, sb, div0, ovf, ok, fix_neg;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res, quo_nxt, fin;
  logic [XLEN:0]     msum, shl, rem_nxt;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_nxt, step_acc, fix_in, fixed;
  assign is_div_i = bus.funct3[2];
  assign sa       = rs1_signed(bus.funct3) & bus.rs1[XLEN-1];
  assign sb       = rs2_signed(bus.funct3) & bus.rs2[XLEN-1];
  muldiv_cneg #(.W(XLEN)) u_neg_a (.a_i(bus.rs1), .neg_i(sa), .y_o(a_mag));
  muldiv_cneg #(.W(XLEN)) u_neg_b (.a_i(bus.rs2), .neg_i(sb), .y_o(b_mag));
  assign div0     = is_div_i & (bus.rs2 == '0);
  assign ovf      = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM)
                    & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2 == '1);
  assign spec_res = div0 ? (bus.funct3[1] ? bus.rs1 : '1) : (bus.funct3[1] ? '0 : bus.rs1);
  // multiplier sits in the low half and shifts out as the product shifts in
  assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt  = {msum, acc_q[XLEN-1:1]};
  // dividend occupies the low half and is consumed MSB first as quotient bits fill in
  assign shl      = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign diff     = {1'b0, shl} - {2'b0, opnd_q};
  assign ok       = ~diff[XLEN+1];
  assign rem_nxt  = ok ? diff[XLEN:0] : shl;
  assign quo_nxt  = {acc_q[XLEN-2:0], ok};
  assign is_div_q = f3_q[2];
  assign step_acc = is_div_q ? {acc_q[2*XLEN-1:XLEN], quo_nxt} : mul_nxt;
  assign fix_in   = is_div_q ? {{XLEN{1'b0}}, f3_q[1] ? rem_nxt[XLEN-1:0] : quo_nxt} : mul_nxt;
  assign fix_neg  = (is_div_q & f3_q[1]) ? sa_q : sa_q ^ sb_q;
  muldiv_cneg #(.W(2*XLEN)) u_neg_r (.a_i(fix_in), .neg_i(fix_neg), .y_o(fixed));
  assign fin      = (f3_q == F3_MUL || is_div_q) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      MD_IDLE: if (bus.start && !bus.flush) begin
        f3_d    = bus.funct3;
        sa_d    = sa;
        sb_d    = sb;
        opnd_d  = is_div_i ? b_mag : a_mag;
        acc_d   = {{XLEN{1'b0}}, is_div_i ? a_mag : b_mag};
        rem_d   = '0;
        cnt_d   = '0;
        res_d   = (div0 || ovf) ? spec_res : res_q;
        state_d = (div0 || ovf) ? MD_DONE : MD_CALC;
      end
      MD_CALC: if (bus.flush) begin
        state_d = MD_IDLE;
      end else begin
        acc_d = step_acc;
        rem_d = rem_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = MD_DONE;
          res_d   = fin;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      f3_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
  assign bus.stall     = (state_q == MD_IDLE && bus.start && !bus.flush) || state_q == MD_CALC;
  assign bus.valid_out = state_q == MD_DONE && !bus.flush;
  assign bus.result    = res_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven checks of muldiv_seq plus flush, reset and ignored-start sequences.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;
  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp;
  muldiv_seq_if #(.XLEN(32)) bus ();
  muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  n;
    bit  seen, stall_ok, stall_at_valid;
    @(negedge clk);
    bus.funct3 = f;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.start  = 1;
    #1 chk({name, ":stall_accept"}, {31'b0, bus.stall}, 32'd1);
    n = 0;
    seen = 0;
    stall_ok = 1;
    stall_at_valid = 1;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start  = 0;
      bus.funct3 = ~f;
      bus.rs1    = ~a;
      bus.rs2    = ~b;
      #1;
      if (bus.valid_out) begin
        seen = 1;
        stall_at_valid = bus.stall;
      end else if (!bus.stall) stall_ok = 0;
    end
    chk({name, ":latency"}, n, lat);
    chk({name, ":result"}, bus.result, exp);
    chk({name, ":stall_busy"}, {31'b0, stall_ok}, 32'd1);
    chk({name, ":stall_at_valid"}, {31'b0, stall_at_valid}, 32'd0);
    @(negedge clk);
    #1 chk({name, ":valid_pulse"}, {31'b0, bus.valid_out}, 32'd0);
    last_exp = exp;
  endtask
  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1 if (bus.valid_out) pulses++;
    end
  endtask
  vec_t vecs[$];
  initial begin
    int p;
    bus.start  = 0;
    bus.flush  = 0;
    bus.funct3 = 0;
    bus.rs1    = 0;
    bus.rs2    = 0;
    vecs = '{
      '{"mul_neg",     F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33},
      '{"mul_plain",   F3_MUL,    32'h12345678,   32'h00000010, 32'h23456780, 33},
      '{"mulh_min",    F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33},
      '{"mulh_m1x5",   F3_MULH,   32'hFFFFFFFF,   32'd5,        32'hFFFFFFFF, 33},
      '{"mulhu_max",   F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33},
      '{"mulhu_x4",    F3_MULHU,  32'h80000000,   32'd4,        32'h00000002, 33},
      '{"mulhsu_max",  F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33},
      '{"div_neg",     F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33},
      '{"rem_neg",     F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33},
      '{"div_negb",    F3_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33},
      '{"rem_negb",    F3_REM,    32'd7,          32'hFFFFFFFE, 32'h00000001, 33},
      '{"divu",        F3_DIVU,   32'd100,        32'd7,        32'd14,       33},
      '{"remu",        F3_REMU,   32'd100,        32'd7,        32'd2,        33},
      '{"divu_big",    F3_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, 33},
      '{"remu_big",    F3_REMU,   32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33},
      '{"divu_zero",   F3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1},
      '{"div_zero",    F3_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1},
      '{"rem_zero",    F3_REM,    32'd5,          32'd0,        32'd5,        1},
      '{"remu_zero",   F3_REMU,   32'd9,          32'd0,        32'd9,        1},
      '{"div_ovf",     F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1},
      '{"rem_ovf",     F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1}
    };
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset:result", bus.result, 32'd0);
    chk("reset:valid", {31'b0, bus.valid_out}, 32'd0);
    chk("reset:stall", {31'b0, bus.stall}, 32'd0);
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    @(negedge clk);
    bus.funct3 = F3_DIVU;
    bus.rs1    = 32'd100;
    bus.rs2    = 32'd7;
    bus.start  = 1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    bus.flush = 1;
    #1 chk("flush:stall_in_calc", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.flush = 0;
    #1;
    chk("flush:stall_idle", {31'b0, bus.stall}, 32'd0);
    chk("flush:valid", {31'b0, bus.valid_out}, 32'd0);
    chk("flush:result_kept", bus.result, last_exp);
    count_valid(40, p);
    chk("flush:no_pulse", p, 0);
    run_op("after_flush_mul", F3_MUL, 32'd3, 32'd4, 32'd12, 33);
    @(negedge clk);
    bus.funct3 = F3_MULHU;
    bus.rs1    = 32'hFFFFFFFF;
    bus.rs2    = 32'hFFFFFFFF;
    bus.start  = 1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("midrst:result", bus.result, 32'd0);
    chk("midrst:stall", {31'b0, bus.stall}, 32'd0);
    chk("midrst:valid", {31'b0, bus.valid_out}, 32'd0);
    count_valid(40, p);
    chk("midrst:no_pulse", p, 0);
    @(negedge clk);
    bus.funct3 = F3_DIVU;
    bus.rs1    = 32'd1000;
    bus.rs2    = 32'd10;
    bus.start  = 1;
    @(posedge clk);
    p = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (bus.valid_out) begin
        p++;
        chk("ignore:result", bus.result, 32'd100);
      end
      bus.funct3 = F3_MUL;
      bus.start  = (i == 5 || i == 20 || bus.valid_out) ? 1'b1 : 1'b0;
    end
    bus.start = 0;
    chk("ignore:one_pulse", p, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
